// File: rtl/ysyx_22041071_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, keeps up to MAX_OUT AXI reads
// in flight and hands 32-bit instructions to decode, dropping wrong-path beats by epoch.
module ysyx_22041071_fetch_ctrl #(
   parameter int unsigned       ADDR_W     = 64,
   parameter int unsigned       DATA_W     = 64,
   parameter int unsigned       MAX_OUT    = 2,
   parameter logic [ADDR_W-1:0] START_ADDR = 64'h8000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              brch_sel,
   input  logic              jpc_sel,
   input  logic              jrpc_sel,
   input  logic [ADDR_W-1:0] bpc,
   input  logic [ADDR_W-1:0] jpc,
   input  logic [ADDR_W-1:0] jrpc,
   output logic              ar_valid,
   input  logic              ar_ready,
   output logic [ADDR_W-1:0] ar_addr,
   output logic [7:0]        ar_len,
   output logic [2:0]        ar_size,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [DATA_W-1:0] r_data,
   input  logic [1:0]        r_resp,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [31:0]       inst,
   output logic              inst_err
);

   localparam int unsigned       OFF        = $clog2(DATA_W / 8);
   localparam int unsigned       PW         = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned       CW         = $clog2(MAX_OUT + 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);
   localparam logic [CW-1:0]     CNT_MAX    = CW'(MAX_OUT);
   localparam logic [PW-1:0]     PTR_LAST   = PW'(MAX_OUT - 1);

   typedef enum logic {RUN, HALT} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic                epoch_q, epoch_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]   tag_pc_q [MAX_OUT];
   logic [ADDR_W-1:0]   tag_pc_d [MAX_OUT];
   logic [MAX_OUT-1:0]  tag_ep_q, tag_ep_d;
   logic                hold_q, hold_d;
   logic [ADDR_W-1:0]   ar_pc_q, ar_pc_d;
   logic                ar_ep_q, ar_ep_d;
   logic                fault_pend_q, fault_pend_d;
   logic [ADDR_W-1:0]   fault_pc_q, fault_pc_d;
   logic                redir_prev_q, redir_prev_d;
   logic                drain_q, drain_d;

   logic                redir;
   logic [ADDR_W-1:0]   redir_pc;
   logic [ADDR_W-1:0]   req_pc;
   logic [ADDR_W-1:0]   head_pc;
   logic                head_live;
   logic [31:0]         lane_word;
   logic                ar_fire, r_fire, fault_show;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign redir     = jrpc_sel | jpc_sel | brch_sel;
   assign redir_pc  = jrpc_sel ? jrpc : (jpc_sel ? jpc : bpc);
   assign req_pc    = hold_q ? ar_pc_q : fetch_pc_q;
   assign head_pc   = tag_pc_q[rd_ptr_q];
   assign head_live = (cnt_q != '0) && (tag_ep_q[rd_ptr_q] == epoch_q);
   assign ar_len    = '0;
   assign ar_size   = 3'(OFF);

   if (DATA_W == 64) begin : g_lane64
      assign lane_word = head_pc[2] ? r_data[63:32] : r_data[31:0];
   end else begin : g_lane32
      assign lane_word = r_data[31:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RUN;
         fetch_pc_q   <= START_ADDR;
         epoch_q      <= 1'b0;
         cnt_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         for (int unsigned i = 0; i < MAX_OUT; i++) tag_pc_q[i] <= '0;
         tag_ep_q     <= '0;
         hold_q       <= 1'b0;
         ar_pc_q      <= '0;
         ar_ep_q      <= 1'b0;
         fault_pend_q <= 1'b0;
         fault_pc_q   <= '0;
         redir_prev_q <= 1'b0;
         drain_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         epoch_q      <= epoch_d;
         cnt_q        <= cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         tag_pc_q     <= tag_pc_d;
         tag_ep_q     <= tag_ep_d;
         hold_q       <= hold_d;
         ar_pc_q      <= ar_pc_d;
         ar_ep_q      <= ar_ep_d;
         fault_pend_q <= fault_pend_d;
         fault_pc_q   <= fault_pc_d;
         redir_prev_q <= redir_prev_d;
         drain_q      <= drain_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      epoch_d      = epoch_q;
      cnt_d        = cnt_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      tag_pc_d     = tag_pc_q;
      tag_ep_d     = tag_ep_q;
      hold_d       = hold_q;
      ar_pc_d      = ar_pc_q;
      ar_ep_d      = ar_ep_q;
      fault_pend_d = fault_pend_q;
      fault_pc_d   = fault_pc_q;
      redir_prev_d = redir;
      drain_d      = drain_q;
      ar_fire      = ar_valid && ar_ready;
      r_fire       = r_valid && r_ready;

      // The PC advances once a request is committed to the bus, so a held request never re-advances it.
      if (ar_fire) begin
         tag_pc_d[wr_ptr_q] = req_pc;
         tag_ep_d[wr_ptr_q] = hold_q ? ar_ep_q : epoch_q;
         wr_ptr_d           = ptr_inc(wr_ptr_q);
         hold_d             = 1'b0;
         if (!hold_q) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end else if (ar_valid && !hold_q) begin
         hold_d     = 1'b1;
         ar_pc_d    = fetch_pc_q;
         ar_ep_d    = epoch_q;
         fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end

      if (r_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({ar_fire, r_fire})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      if (fault_show && inst_ready) fault_pend_d = 1'b0;
      if (drain_q && cnt_q == '0 && !hold_q) drain_d = 1'b0;

      // Every tag still in flight, plus any held request, is forced to the retiring
      // epoch so a second toggle can never make an older wrong-path beat look live.
      if (redir) begin
         fetch_pc_d = redir_pc;
         epoch_d    = ~epoch_q;
         ar_ep_d    = epoch_q;
         for (int unsigned i = 0; i < MAX_OUT; i++) tag_ep_d[i] = epoch_q;
         if (redir_prev_q) drain_d = 1'b1;
         if (redir_pc[1:0] != 2'b00) begin
            state_d      = HALT;
            fault_pend_d = 1'b1;
            fault_pc_d   = redir_pc;
         end else begin
            state_d      = RUN;
            fault_pend_d = 1'b0;
         end
      end
   end

   always_comb begin
      ar_valid   = !reset && (hold_q || (state_q == RUN && cnt_q < CNT_MAX && !drain_q));
      ar_addr    = req_pc & ALIGN_MASK;
      r_ready    = 1'b0;
      inst_valid = 1'b0;
      inst_pc    = '0;
      inst       = '0;
      inst_err   = 1'b0;
      fault_show = 1'b0;
      if (cnt_q != '0) begin
         if (head_live) begin
            r_ready    = inst_ready;
            inst_valid = r_valid;
            inst_pc    = head_pc;
            if (r_valid) begin
               inst     = lane_word;
               inst_err = (r_resp != 2'b00);
            end
         end else begin
            r_ready = 1'b1;
         end
      end else if (fault_pend_q && !hold_q) begin
         fault_show = 1'b1;
         inst_valid = 1'b1;
         inst_err   = 1'b1;
         inst_pc    = fault_pc_q;
      end
   end

endmodule

// File: tb/tb_ysyx_22041071_fetch_ctrl.sv
// Directed bench for the fetch controller; a small queue acts as the AXI memory,
// returning each 32-bit word's own address as its data.
module tb_ysyx_22041071_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        brch_sel, jpc_sel, jrpc_sel;
   logic [63:0] bpc, jpc, jrpc;
   logic        ar_valid, ar_ready;
   logic [63:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic        r_valid, r_ready;
   logic [63:0] r_data;
   logic [1:0]  r_resp;
   logic        inst_valid, inst_ready;
   logic [63:0] inst_pc;
   logic [31:0] inst;
   logic        inst_err;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   int unsigned n_arf  = 0;
   int unsigned n0;
   logic        rv_en;
   logic [63:0] memq [$];
   logic [63:0] exp_ar, exp_pc;

   always #5 clk = ~clk;

   ysyx_22041071_fetch_ctrl #(
      .ADDR_W(64), .DATA_W(64), .MAX_OUT(2), .START_ADDR(64'h8000_0000)
   ) dut (
      .clk(clk), .reset(reset),
      .brch_sel(brch_sel), .jpc_sel(jpc_sel), .jrpc_sel(jrpc_sel),
      .bpc(bpc), .jpc(jpc), .jrpc(jrpc),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
      .ar_len(ar_len), .ar_size(ar_size),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
      .inst(inst), .inst_err(inst_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      logic [63:0] a;
      r_valid = rv_en && (memq.size() != 0);
      if (memq.size() != 0) begin
         a      = memq[0];
         r_data = {a[31:0] + 32'd4, a[31:0]};
      end else begin
         r_data = '0;
      end
      #1;
   endtask

   task automatic cycle();
      logic        arf, rf;
      logic [63:0] a, dropped;
      arf = ar_valid && ar_ready;
      rf  = r_valid && r_ready;
      a   = ar_addr;
      @(posedge clk);
      #1;
      if (arf) begin
         memq.push_back(a);
         n_arf++;
      end
      if (rf) dropped = memq.pop_front();
      drive();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      {brch_sel, jpc_sel, jrpc_sel} = '0;
      ar_ready = 1'b0; rv_en = 1'b0; inst_ready = 1'b0; r_resp = 2'b00;
      drive();
      cycle();
      cycle();
      memq.delete();
      reset = 1'b0;
      drive();
   endtask

   initial begin
      bpc = '0; jpc = '0; jrpc = '0; r_data = '0;
      reset = 1'b1;
      {brch_sel, jpc_sel, jrpc_sel} = '0;
      ar_ready = 1'b0; rv_en = 1'b0; inst_ready = 1'b0; r_resp = 2'b00;
      drive();
      cycle();
      cycle();
      chk("rst_ar_valid", ar_valid, 64'd0);
      chk("rst_r_ready", r_ready, 64'd0);
      chk("rst_inst_valid", inst_valid, 64'd0);
      chk("rst_inst_err", inst_err, 64'd0);
      chk("rst_inst", inst, 64'd0);
      chk("ar_len", ar_len, 64'd0);
      chk("ar_size", ar_size, 64'd3);
      reset = 1'b0;
      drive();
      chk("first_ar_valid", ar_valid, 64'd1);
      chk("first_ar_addr", ar_addr, 64'h8000_0000);

      // free-running stream
      ar_ready = 1'b1; rv_en = 1'b1; inst_ready = 1'b1;
      drive();
      for (int k = 0; k < 8; k++) begin
         exp_ar = 64'h8000_0000 + 64'(8 * (k / 2));
         chk("run_ar_addr", ar_addr, exp_ar);
         if (k > 0) begin
            exp_pc = 64'h8000_0000 + 64'(4 * (k - 1));
            chk("run_inst_valid", inst_valid, 64'd1);
            chk("run_inst_pc", inst_pc, exp_pc);
            chk("run_inst", inst, {32'd0, exp_pc[31:0]});
         end
         cycle();
      end

      // read backpressure: only MAX_OUT requests go out
      do_reset();
      ar_ready = 1'b1; inst_ready = 1'b1; rv_en = 1'b0;
      drive();
      n0 = n_arf;
      for (int k = 0; k < 4; k++) cycle();
      chk("bp_ar_count", 64'(n_arf - n0), 64'd2);
      chk("bp_ar_valid_full", ar_valid, 64'd0);
      rv_en = 1'b1;
      drive();
      chk("bp_inst_pc", inst_pc, 64'h8000_0000);
      chk("bp_ar_valid_still0", ar_valid, 64'd0);
      cycle();
      rv_en = 1'b0;
      drive();
      chk("bp_ar_reassert", ar_valid, 64'd1);
      chk("bp_ar_addr", ar_addr, 64'h8000_0008);

      // redirect with two requests in flight
      do_reset();
      ar_ready = 1'b1; inst_ready = 1'b0; rv_en = 1'b0;
      drive();
      cycle();
      cycle();
      chk("rd_full", ar_valid, 64'd0);
      jpc_sel = 1'b1; jpc = 64'h8000_0100;
      drive();
      cycle();
      jpc_sel = 1'b0; rv_en = 1'b1;
      drive();
      chk("rd_stale0_r_ready", r_ready, 64'd1);
      chk("rd_stale0_inst_valid", inst_valid, 64'd0);
      cycle();
      chk("rd_stale1_r_ready", r_ready, 64'd1);
      chk("rd_stale1_inst_valid", inst_valid, 64'd0);
      cycle();
      chk("rd_new_inst_valid", inst_valid, 64'd1);
      chk("rd_new_inst_pc", inst_pc, 64'h8000_0100);
      chk("rd_new_inst", inst, 64'h8000_0100);
      chk("rd_new_r_ready", r_ready, 64'd0);

      // redirect while an AR is held off by ar_ready=0
      do_reset();
      ar_ready = 1'b0; inst_ready = 1'b1; rv_en = 1'b0;
      drive();
      chk("hold_ar_valid", ar_valid, 64'd1);
      cycle();
      jrpc_sel = 1'b1; jrpc = 64'h8000_0200;
      drive();
      chk("hold_addr_a", ar_addr, 64'h8000_0000);
      cycle();
      jrpc_sel = 1'b0;
      drive();
      chk("hold_addr_b", ar_addr, 64'h8000_0000);
      chk("hold_valid_b", ar_valid, 64'd1);
      ar_ready = 1'b1;
      drive();
      cycle();
      rv_en = 1'b1;
      drive();
      chk("hold_new_addr", ar_addr, 64'h8000_0200);
      chk("hold_old_r_ready", r_ready, 64'd1);
      chk("hold_old_inst_valid", inst_valid, 64'd0);
      cycle();
      chk("hold_new_inst_valid", inst_valid, 64'd1);
      chk("hold_new_inst_pc", inst_pc, 64'h8000_0200);

      // redirect priority
      do_reset();
      ar_ready = 1'b1; inst_ready = 1'b1; rv_en = 1'b0;
      brch_sel = 1'b1; jpc_sel = 1'b1; jrpc_sel = 1'b1;
      bpc = 64'h8000_0300; jpc = 64'h8000_0400; jrpc = 64'h8000_0500;
      drive();
      cycle();
      jrpc_sel = 1'b0;
      drive();
      chk("pri_all_jrpc", ar_addr, 64'h8000_0500);
      cycle();
      brch_sel = 1'b0; jpc_sel = 1'b0;
      drive();
      chk("pri_jpc_over_brch", ar_addr, 64'h8000_0400);

      // SLVERR beat, then misaligned branch target
      do_reset();
      ar_ready = 1'b1; inst_ready = 1'b1; rv_en = 1'b0;
      drive();
      cycle();
      rv_en = 1'b1; r_resp = 2'b10;
      drive();
      chk("err_inst_valid", inst_valid, 64'd1);
      chk("err_inst_err", inst_err, 64'd1);
      chk("err_inst_pc", inst_pc, 64'h8000_0000);
      chk("err_inst", inst, 64'h8000_0000);
      cycle();
      rv_en = 1'b0; r_resp = 2'b00;
      brch_sel = 1'b1; bpc = 64'h8000_0002;
      drive();
      chk("err_fetch_continues", ar_valid, 64'd1);
      cycle();
      brch_sel = 1'b0; rv_en = 1'b1;
      drive();
      n0 = n_arf;
      chk("mis_ar_valid", ar_valid, 64'd0);
      chk("mis_stale0_inst_valid", inst_valid, 64'd0);
      chk("mis_stale0_r_ready", r_ready, 64'd1);
      cycle();
      chk("mis_stale1_inst_valid", inst_valid, 64'd0);
      cycle();
      chk("mis_fault_valid", inst_valid, 64'd1);
      chk("mis_fault_err", inst_err, 64'd1);
      chk("mis_fault_pc", inst_pc, 64'h8000_0002);
      chk("mis_fault_inst", inst, 64'd0);
      chk("mis_fault_ar_valid", ar_valid, 64'd0);
      cycle();
      chk("mis_fault_once", inst_valid, 64'd0);
      chk("mis_halt_ar_valid", ar_valid, 64'd0);
      cycle();
      cycle();
      chk("mis_no_ar", 64'(n_arf - n0), 64'd0);
      jpc_sel = 1'b1; jpc = 64'h8000_0600;
      drive();
      cycle();
      jpc_sel = 1'b0;
      drive();
      chk("mis_resume_valid", ar_valid, 64'd1);
      chk("mis_resume_addr", ar_addr, 64'h8000_0600);
      chk("mis_resume_err", inst_err, 64'd0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
